// File: rtl/mult_rr_sched_pkg.sv
// mult_rr_sched_pkg: width helpers shared by the multiplier scheduler and its picker.
package mult_rr_sched_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/mult_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last+1 with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;
  // Scan farthest candidate first so the nearest one after last wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: one shared unsigned multiplier, round-robin among requesters,
// single-entry output register refilled in the cycle it drains.
module mult_rr_sched
  import mult_rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [prod_w(WIDTH)-1:0] rsp_product,
  output logic [CNTW-1:0]         ops_done,
  output logic                    busy
);
  localparam int PW = prod_w(WIDTH);
  logic            free, take, any;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  g;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d, last_q, last_d;
  logic [PW-1:0]   rsp_product_q, rsp_product_d;
  logic [CNTW-1:0] ops_q, ops_d;
  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req (req_valid),
    .last(last_q),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );
  always_comb begin
    free = !rsp_valid_q || rsp_ready;
    take = free && any && rst_n;
    req_ready = take ? gnt : '0;
    a_sel = req_a[int'(g)*WIDTH +: WIDTH];
    b_sel = req_b[int'(g)*WIDTH +: WIDTH];
    rsp_valid_d = take || (rsp_valid_q && !rsp_ready);
    rsp_id_d = take ? g : rsp_id_q;
    rsp_product_d = take ? PW'(a_sel) * PW'(b_sel) : rsp_product_q;
    last_d = take ? g : last_q;
    ops_d = (rsp_valid_q && rsp_ready && !(&ops_q)) ? ops_q + CNTW'(1) : ops_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_product_q <= '0;
      ops_q <= '0;
      last_q <= IDW'(NREQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      ops_q <= ops_d;
      last_q <= last_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign ops_done = ops_q;
  assign busy = rsp_valid_q || (|req_valid);
endmodule

// File: tb/tb_mult_rr_sched.sv
// tb_mult_rr_sched: directed jobs with a response scoreboard; a second instance
// with a 3-bit counter shares the stimulus to exercise saturation.
module tb_mult_rr_sched;
  logic        clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  a[4], b[4];
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready, req_ready2;
  logic        rsp_valid, rsp_valid2, busy, busy2;
  logic [1:0]  rsp_id, rsp_id2;
  logic [7:0]  rsp_product, rsp_product2;
  logic [15:0] ops_done;
  logic [2:0]  ops_done2;
  typedef struct { logic [1:0] id; logic [7:0] p; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [3:0]  pv = '0, pr = '0;
  logic [15:0] pa = '0, pb = '0;

  assign req_a = {a[3], a[2], a[1], a[0]};
  assign req_b = {b[3], b[2], b[1], b[0]};
  always #5 clk = ~clk;

  mult_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .ops_done(ops_done), .busy(busy)
  );
  mult_rr_sched #(.CNTW(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id2), .rsp_product(rsp_product2), .ops_done(ops_done2), .busy(busy2)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int id, input int p);
    q.push_back(exp_t'{2'(id), 8'(p)});
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id %0d product %0d expected none", rsp_id, rsp_product);
      end else begin
        e = q.pop_front();
        if (rsp_id !== e.id || rsp_product !== e.p) begin
          errors++;
          $display("FAIL rsp: got id %0d product %0d expected id %0d product %0d",
                   rsp_id, rsp_product, e.id, e.p);
        end
      end
    end
  end

  // Operands of a pending, ungranted job must not change.
  always @(negedge clk) begin
    if (rst_n)
      for (int i = 0; i < 4; i++)
        if (pv[i] && !pr[i] && req_valid[i] &&
            (req_a[i*4 +: 4] !== pa[i*4 +: 4] || req_b[i*4 +: 4] !== pb[i*4 +: 4])) begin
          errors++;
          $display("FAIL operand_hold: requester %0d changed operands while pending", i);
        end
    pv <= req_valid;
    pr <= req_ready;
    pa <= req_a;
    pb <= req_b;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int id;
    for (int i = 0; i < 4; i++) begin a[i] = '0; b[i] = '0; end
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_product", 32'(rsp_product), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_busy", 32'(busy), 0);
    cyc();
    a[0] = 3; b[0] = 5; req_valid = 4'b0001; push(0, 15);
    @(negedge clk); chk("single_ready", 32'(req_ready), 32'b0001);
    cyc(); req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 0);
    chk("single_product", 32'(rsp_product), 15);
    cyc(); rsp_ready = 1'b1;
    @(negedge clk);
    cyc(); rsp_ready = 1'b0;
    @(negedge clk);
    chk("single_ops", 32'(ops_done), 1);
    chk("single_drained", 32'(rsp_valid), 0);
    cyc();
    for (int i = 0; i < 4; i++) begin a[i] = 4'(i + 1); b[i] = 2; end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      id = (k + 1) % 4;
      push(id, (id + 1) * 2);
      @(negedge clk); chk("rr_grant", 32'(req_ready), 32'(1) << id);
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("rr_ops", 32'(ops_done), 6);
    cyc();
    a[0] = 1; a[1] = 3; a[2] = 5; a[3] = 7;
    for (int i = 0; i < 4; i++) b[i] = 3;
    rsp_ready = 1'b0; req_valid = 4'b0010; push(1, 9);
    @(negedge clk); chk("bp_first_ready", 32'(req_ready), 32'b0010);
    cyc(); req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_product", 32'(rsp_product), 9);
      cyc();
    end
    rsp_ready = 1'b1; push(2, 15);
    @(negedge clk); chk("bp_release_grant", 32'(req_ready), 32'b0100);
    cyc(); req_valid = '0;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("bp_ops", 32'(ops_done), 8);
    cyc();
    a[3] = 15; b[3] = 15; req_valid = 4'b1000; push(3, 225);
    @(negedge clk); chk("max_ready", 32'(req_ready), 32'b1000);
    cyc(); a[0] = 0; b[0] = 15; req_valid = 4'b0001; push(0, 0);
    @(negedge clk); chk("zero_ready", 32'(req_ready), 32'b0001);
    cyc(); a[1] = 1; b[1] = 15; req_valid = 4'b0010; push(1, 15);
    @(negedge clk); chk("one_ready", 32'(req_ready), 32'b0010);
    cyc(); req_valid = '0;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("arith_ops", 32'(ops_done), 11);
    cyc();
    rsp_ready = 1'b0; a[2] = 2; b[2] = 2; req_valid = 4'b0100;
    @(negedge clk);
    cyc(); req_valid = '0;
    @(negedge clk); chk("flight_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_ops", 32'(ops_done), 0);
    chk("async_ops2", 32'(ops_done2), 0);
    chk("async_product", 32'(rsp_product), 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();
    a[0] = 2; b[0] = 3; a[3] = 4; b[3] = 5; req_valid = 4'b1001; rsp_ready = 1'b1;
    push(0, 6);
    @(negedge clk); chk("post_rst_grant0", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b1000; push(3, 20);
    @(negedge clk); chk("post_rst_grant3", 32'(req_ready), 32'b1000);
    cyc(); req_valid = '0;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("post_rst_ops", 32'(ops_done), 2);
    cyc();
    for (int i = 0; i < 4; i++) begin a[i] = 4'(i + 1); b[i] = 1; end
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      id = k % 4;
      push(id, id + 1);
      @(negedge clk); chk("sat_grant", 32'(req_ready), 32'(1) << id);
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("sat_ops16", 32'(ops_done), 14);
    chk("sat_ops3", 32'(ops_done2), 7);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
